irq_pending_ctrl: RTL and testbench
===================================

// Module: irq_pending_ctrl
// PURPOSE
// - Upstream request-capture stage for the L-bit priority encoder.
// - Latches request events into a sticky pending vector and applies a per-bit enable mask.
// - Presents the highest-index eligible request to a consumer over a valid/ready handshake.
// - Clears the accepted bit on handshake completion.
// PARAMETERS
// - L   4              number of request lines; legal range L >= 2.
// - W   $clog2(L)      localparam; index width. Not overridable.
// PORTS
// - clk        in   1   rising-edge clock.
// - rst        in   1   asynchronous reset, active-high.
// - req        in   L   request lines; bit i = source i.
// - mask       in   L   1 = source enabled for selection. Capture into pending is unaffected by mask.
// - out_valid  out  1   out_idx holds a valid selected source.
// - out_ready  in   1   consumer accepts when out_valid && out_ready at a clk edge.
// - out_idx    out  W   selected source index. Highest eligible index wins.
// - pending    out  L   registered sticky pending vector.
// - overflow   out  1   one-cycle pulse: a capture hit a bit that was already pending and not being cleared.
// BEHAVIOUR
// - Reset (async, immediate): pending=0, out_valid=0, out_idx=0, overflow=0, state=IDLE, req_d=0.
// - Capture: cap = req (level mode) or req & ~req_d (edge mode); req_d is req registered.
// - Pending update: pending <= (pending & ~clr) | cap.
//   - clr is one-hot at out_idx on a handshake, else 0.
//   - If the same bit is captured and cleared in one cycle, the set wins and the bit stays pending.
// - overflow <= |(cap & pending & ~clr); registered, 1-cycle pulse.
// - eligible = pending & mask; sel = index of the highest set bit of eligible.
// - FSM has two states:
//   - IDLE: out_valid=0. If |eligible, then out_idx<=sel, out_valid<=1, go PRESENT.
//   - PRESENT: out_idx and out_valid are held stable until handshake.
//     - Not retracted or re-prioritised by new higher requests or by mask changes.
//     - On out_valid && out_ready: clr bit out_idx, out_valid<=0, go IDLE.
// - Latency: req sampled at edge N -> pending at N -> out_valid/out_idx at edge N+1.
// - After every handshake, out_valid is low for at least one cycle (the IDLE re-evaluation).
// - Handshake throughput is at most one grant per 2 cycles.
// - Masked pending bits stay pending indefinitely. They are selected the IDLE cycle after unmask.
// - out_ready while out_valid=0 is ignored.
// - rst mid-PRESENT drops out_valid asynchronously. In-flight grant and all pending are lost.
// CONFIGURATION
// - IRQ_EDGE_EN defined: rising-edge capture.
//   - A request held high sets pending once.
//   - It must drop low and rise again to re-capture.
// - IRQ_EDGE_EN undefined: level capture.
//   - A held request re-sets its bit every cycle; a bit cleared by handshake re-pends next edge.
//   - While the held bit is already pending, overflow pulses every cycle.
// - req_d is removed when IRQ_EDGE_EN is undefined.
// TESTING
// - Idle: rst pulse, then req=0000, mask=1111 for 10 cycles
//   -> out_valid=0, pending=0000, overflow=0 throughout.
// - Priority: req=0101 for 1 cycle, out_ready=0 -> pending=0101.
//   - Next edge: out_valid=1, out_idx=2; held 5 cycles.
//   - out_ready=1 -> pending=0001, one cycle out_valid=0, then out_idx=0 presented.
// - Stability: presenting idx 0 with ready=0, pulse req=1000
//   -> out_idx stays 0; after accept, the next presentation is out_idx=3.
// - Mask: mask=1011, req=0100 pulse -> pending=0100, out_valid stays 0.
//   - mask=1111 -> out_valid=1, out_idx=2 the edge after the IDLE evaluation.
// - Overflow/collision: pending=0010, pulse req=0010 -> overflow=1 for 1 cycle.
//   - Accept idx 1 in the same cycle as req=0010 -> pending stays 0010, overflow=0.
// - Mode and reset:
//   - Hold req=0001 high through an accept: pending re-sets (level) or stays 0 (IRQ_EDGE_EN).
//   - Assert rst during PRESENT -> out_valid=0 and pending=0 before the next clk edge.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// Sticky request capture with masked highest-index selection and valid/ready grant.
// Define IRQ_EDGE_EN for rising-edge capture; level capture otherwise.
module irq_pending_ctrl #(
    parameter  int L = 4,
    localparam int W = $clog2(L)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [L-1:0] req,
    input  logic [L-1:0] mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [L-1:0] pending,
    output logic         overflow
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [L-1:0] pending_q, pending_d;
    logic         ovf_q, ovf_d;
    logic [L-1:0] cap;
    logic [L-1:0] clr;
    logic [L-1:0] eligible;
    logic [W-1:0] sel;
    logic         hs;

`ifdef IRQ_EDGE_EN
    logic [L-1:0] req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= '0;
        else     req_q <= req;
    end

    assign cap = req & ~req_q;
`else
    assign cap = req;
`endif

    assign hs       = (state_q == PRESENT) && out_ready;
    assign eligible = pending_q & mask;

    always_comb begin
        clr = '0;
        if (hs) clr[idx_q] = 1'b1;
    end

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < L; i++) begin
            if (eligible[i]) sel = W'(i);
        end
    end

    // A capture landing on the bit being cleared keeps it pending.
    always_comb begin
        pending_d = (pending_q & ~clr) | cap;
        ovf_d     = |(cap & pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|eligible) state_d = PRESENT;
            PRESENT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (state_q == IDLE && |eligible) idx_d = sel;
        out_valid = (state_q == PRESENT);
    end

    assign out_idx  = idx_q;
    assign pending  = pending_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scenario bench for irq_pending_ctrl; expected grant order is queued at stimulus time.
module tb_irq_pending_ctrl;

    localparam int L = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [L-1:0] req;
    logic [L-1:0] mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [L-1:0] pending;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    irq_pending_ctrl #(.L(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mask     (mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        mask = '1;
        out_ready = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, out_idx, pending, overflow} !== 8'b0) begin
            bad++;
            $display("FAIL reset got=%b want=%b",
                     {out_valid, out_idx, pending, overflow}, 8'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({out_valid, pending, overflow} !== 6'b0) begin
                bad++;
                $display("FAIL idle[%0d] got=%b want=%b", i,
                         {out_valid, pending, overflow}, 6'b0);
            end
        end
    endtask

    task automatic test_priority();
        int e;
        req = 4'b0101;
        exp_q.push_back(2);
        exp_q.push_back(0);
        step();
        req = '0;
        total++;
        if ({out_valid, pending} !== 5'b0_0101) begin
            bad++;
            $display("FAIL prio_capture got=%b want=%b", {out_valid, pending}, 5'b0_0101);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({out_valid, out_idx} !== 3'b1_10) begin
                bad++;
                $display("FAIL prio_hold[%0d] got=%b want=%b", i, {out_valid, out_idx}, 3'b1_10);
            end
        end
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL prio_grant0 got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, pending} !== 5'b0_0001) begin
            bad++;
            $display("FAIL prio_after_accept got=%b want=%b", {out_valid, pending}, 5'b0_0001);
        end
        step();
        total++;
        if ({out_valid, out_idx} !== 3'b1_00) begin
            bad++;
            $display("FAIL prio_next got=%b want=%b", {out_valid, out_idx}, 3'b1_00);
        end
    endtask

    task automatic test_stability();
        int e;
        req = 4'b1000;
        exp_q.push_back(3);
        step();
        req = '0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({out_valid, out_idx, pending} !== 7'b1_00_1001) begin
                bad++;
                $display("FAIL stab_hold[%0d] got=%b want=%b", i,
                         {out_valid, out_idx, pending}, 7'b1_00_1001);
            end
            if (i == 0) step();
        end
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL stab_grant0 got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, pending} !== 5'b0_1000) begin
            bad++;
            $display("FAIL stab_gap got=%b want=%b", {out_valid, pending}, 5'b0_1000);
        end
        step();
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL stab_grant3 got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, pending} !== 5'b0_0000) begin
            bad++;
            $display("FAIL stab_drain got=%b want=%b", {out_valid, pending}, 5'b0);
        end
    endtask

    task automatic test_mask();
        int e;
        mask = 4'b1011;
        req = 4'b0100;
        step();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_valid, pending} !== 5'b0_0100) begin
                bad++;
                $display("FAIL mask_block[%0d] got=%b want=%b", i, {out_valid, pending}, 5'b0_0100);
            end
            if (i < 3) step();
        end
        mask = '1;
        exp_q.push_back(2);
        step();
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL mask_unmask got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        out_ready = 1'b0;
        total++;
        if (pending !== 4'b0000) begin
            bad++;
            $display("FAIL mask_drain got=%b want=%b", pending, 4'b0);
        end
    endtask

    task automatic test_overflow();
        int e;
        req = 4'b0010;
        exp_q.push_back(1);
        exp_q.push_back(1);
        step();
        req = '0;
        total++;
        if ({pending, overflow} !== 5'b0010_0) begin
            bad++;
            $display("FAIL ovf_first got=%b want=%b", {pending, overflow}, 5'b0010_0);
        end
        step();
        req = 4'b0010;
        step();
        req = '0;
        total++;
        if ({out_valid, out_idx, overflow} !== 4'b1_01_1) begin
            bad++;
            $display("FAIL ovf_pulse got=%b want=%b", {out_valid, out_idx, overflow}, 4'b1_01_1);
        end
        step();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_one_cycle got=%b want=0", overflow);
        end
        req = 4'b0010;
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL ovf_grant got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        req = '0;
        out_ready = 1'b0;
        total++;
        if ({out_valid, pending, overflow} !== 6'b0_0010_0) begin
            bad++;
            $display("FAIL ovf_collide got=%b want=%b",
                     {out_valid, pending, overflow}, 6'b0_0010_0);
        end
        step();
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL ovf_regrant got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_mode_reset();
        int e;
        logic       exp_ovf;
        logic [3:0] exp_pend;
`ifdef IRQ_EDGE_EN
        exp_ovf  = 1'b0;
        exp_pend = 4'b0000;
`else
        exp_ovf  = 1'b1;
        exp_pend = 4'b0001;
`endif
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        total++;
        if (pending !== 4'b0001) begin
            bad++;
            $display("FAIL mode_capture got=%b want=0001", pending);
        end
        step();
        total++;
        if ({out_valid, out_idx, overflow} !== {3'b1_00, exp_ovf}) begin
            bad++;
            $display("FAIL mode_present got=%b want=%b",
                     {out_valid, out_idx, overflow}, {3'b1_00, exp_ovf});
        end
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (int'(out_idx) != e) begin
            bad++;
            $display("FAIL mode_grant got=%0d want=%0d", out_idx, e);
        end
        step();
        out_ready = 1'b0;
        req = '0;
        total++;
        if (pending !== exp_pend) begin
            bad++;
            $display("FAIL mode_held_req got=%b want=%b", pending, exp_pend);
        end
`ifndef IRQ_EDGE_EN
        exp_q.push_back(0);
        step();
        out_ready = 1'b1;
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (out_valid !== 1'b1 || int'(out_idx) != e) begin
            bad++;
            $display("FAIL mode_repend got=%0d/%b want=%0d/1", out_idx, out_valid, e);
        end
`endif
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, pending} !== 5'b0) begin
            bad++;
            $display("FAIL mode_drain got=%b want=%b", {out_valid, pending}, 5'b0);
        end
        req = 4'b1000;
        step();
        req = '0;
        step();
        total++;
        if ({out_valid, out_idx} !== 3'b1_11) begin
            bad++;
            $display("FAIL rst_pre got=%b want=%b", {out_valid, out_idx}, 3'b1_11);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, pending, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async got=%b want=%b", {out_valid, pending, overflow}, 6'b0);
        end
        #2;
        rst = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, pending} !== 5'b0) begin
            bad++;
            $display("FAIL rst_lost got=%b want=%b", {out_valid, pending}, 5'b0);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_priority();
        test_stability();
        test_mask();
        test_overflow();
        test_mode_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
